// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch-side bus between the core's fetch stage and the instruction store.
interface imem_responder_if;
    logic [31:2] mem_addr_I;
    logic        mem_ren_I;
    logic [31:0] mem_rdata_I;
    logic        mem_stall_I;
    logic        mem_err_I;
    modport master (output mem_addr_I, mem_ren_I, input mem_rdata_I, mem_stall_I, mem_err_I);
    modport slave  (input mem_addr_I, mem_ren_I, output mem_rdata_I, mem_stall_I, mem_err_I);
endinterface

// File: rtl/imem_responder.sv
// imem_responder: instruction store answering fetches after LATENCY wait states, with a program-load port.
module imem_responder #(
    parameter int          DEPTH_LOG2 = 8,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_responder_if.slave       bus,
    input  logic                  load_we,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [31:2]           addr_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [31:2]           rd_addr;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_oor_d;
    logic [31:0]           rd_data_d;
    logic                  resp_enter;
    // The IDLE->RESP edge (LATENCY=1) reads before addr_q is latched, so it uses the live address.
    always_comb begin
        rd_addr    = state_q == IDLE ? bus.mem_addr_I : addr_q;
        rd_idx     = rd_addr[DEPTH_LOG2+1:2];
        rd_oor_d   = |rd_addr[31:DEPTH_LOG2+2];
        rd_data_d  = rd_oor_d ? NOP_WORD : (load_we && load_addr == rd_idx) ? load_data : mem[rd_idx];
        resp_enter = state_q == IDLE ? bus.mem_ren_I && LATENCY == 1 : state_q == WAIT && cnt_q <= 4'd1;
    end
    always_ff @(posedge clk) begin
        if (load_we) mem[load_addr] <= load_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.mem_ren_I) begin
                    addr_q  <= bus.mem_addr_I;
                    cnt_q   <= 4'(LATENCY - 1);
                    state_q <= LATENCY == 1 ? RESP : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
            if (resp_enter) rdata_q <= rd_data_d;
            err_q <= resp_enter & rd_oor_d;
        end
    end
    assign bus.mem_stall_I = state_q == IDLE ? bus.mem_ren_I : state_q == WAIT;
    assign bus.mem_rdata_I = rdata_q;
    assign bus.mem_err_I   = err_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed vectors for LATENCY=2 plus hand sequences for reset and LATENCY=4/1.
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_we = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    imem_responder_if if2 ();
    imem_responder_if if4 ();
    imem_responder_if if1 ();

    imem_responder #(.LATENCY(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data));
    imem_responder #(.LATENCY(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data));
    imem_responder #(.LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

    typedef struct {
        logic        ren;
        logic [29:0] addr;
        logic        we;
        logic [7:0]  la;
        logic [31:0] ld;
        logic        st;
        logic [31:0] rd;
        logic        er;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t v(input logic ren, input logic [29:0] addr, input logic we,
                               input logic [7:0] la, input logic [31:0] ld,
                               input logic st, input logic [31:0] rd, input logic er);
        vec_t r;
        r.ren = ren; r.addr = addr; r.we = we; r.la = la; r.ld = ld;
        r.st = st; r.rd = rd; r.er = er;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if2.mem_ren_I = 0; if2.mem_addr_I = '0;
        if4.mem_ren_I = 0; if4.mem_addr_I = '0;
        if1.mem_ren_I = 0; if1.mem_addr_I = '0;

        // LATENCY=2: load, single fetch, back-to-back, out-of-range, write-first, parallel write
        tv.push_back(v(0, 0, 1, 0, 32'h00500093, 0, 32'h0, 0));
        tv.push_back(v(0, 0, 1, 1, 32'h00108113, 0, 32'h0, 0));
        tv.push_back(v(0, 0, 1, 2, 32'h002081b3, 0, 32'h0, 0));
        tv.push_back(v(0, 0, 1, 3, 32'hfe000ee3, 0, 32'h0, 0));
        tv.push_back(v(0, 0, 1, 5, 32'hAAAAAAAA, 0, 32'h0, 0));
        tv.push_back(v(1, 1, 0, 0, 0, 1, 32'h0, 0));
        tv.push_back(v(1, 1, 0, 0, 0, 1, 32'h0, 0));
        tv.push_back(v(1, 1, 0, 0, 0, 0, 32'h00108113, 0));
        tv.push_back(v(1, 0, 0, 0, 0, 1, 32'h00108113, 0));
        tv.push_back(v(1, 0, 0, 0, 0, 1, 32'h00108113, 0));
        tv.push_back(v(1, 0, 0, 0, 0, 0, 32'h00500093, 0));
        tv.push_back(v(1, 1, 0, 0, 0, 1, 32'h00500093, 0));
        tv.push_back(v(1, 1, 0, 0, 0, 1, 32'h00500093, 0));
        tv.push_back(v(1, 1, 0, 0, 0, 0, 32'h00108113, 0));
        tv.push_back(v(1, 2, 0, 0, 0, 1, 32'h00108113, 0));
        tv.push_back(v(1, 2, 0, 0, 0, 1, 32'h00108113, 0));
        tv.push_back(v(1, 2, 0, 0, 0, 0, 32'h002081b3, 0));
        tv.push_back(v(1, 3, 0, 0, 0, 1, 32'h002081b3, 0));
        tv.push_back(v(1, 7, 0, 0, 0, 1, 32'h002081b3, 0));
        tv.push_back(v(1, 3, 0, 0, 0, 0, 32'hfe000ee3, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 32'hfe000ee3, 0));
        tv.push_back(v(1, 30'h100, 0, 0, 0, 1, 32'hfe000ee3, 0));
        tv.push_back(v(1, 30'h100, 0, 0, 0, 1, 32'hfe000ee3, 0));
        tv.push_back(v(1, 30'h100, 0, 0, 0, 0, 32'h00000013, 1));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 32'h00000013, 0));
        tv.push_back(v(1, 5, 0, 0, 0, 1, 32'h00000013, 0));
        tv.push_back(v(1, 5, 1, 5, 32'h12345678, 1, 32'h00000013, 0));
        tv.push_back(v(1, 5, 0, 0, 0, 0, 32'h12345678, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 32'h12345678, 0));
        tv.push_back(v(1, 5, 0, 0, 0, 1, 32'h12345678, 0));
        tv.push_back(v(1, 5, 1, 6, 32'hCAFEF00D, 1, 32'h12345678, 0));
        tv.push_back(v(1, 5, 0, 0, 0, 0, 32'h12345678, 0));
        tv.push_back(v(1, 6, 0, 0, 0, 1, 32'h12345678, 0));
        tv.push_back(v(1, 6, 0, 0, 0, 1, 32'h12345678, 0));
        tv.push_back(v(1, 6, 0, 0, 0, 0, 32'hCAFEF00D, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0));

        @(negedge clk);
        chk("reset u2 stall", 32'(if2.mem_stall_I), 0);
        chk("reset u2 rdata", if2.mem_rdata_I, 32'h0);
        chk("reset u2 err", 32'(if2.mem_err_I), 0);
        chk("reset u4 rdata", if4.mem_rdata_I, 32'h0);
        chk("reset u1 stall", 32'(if1.mem_stall_I), 0);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            tick();
            if2.mem_ren_I = tv[i].ren; if2.mem_addr_I = tv[i].addr;
            load_we = tv[i].we; load_addr = tv[i].la; load_data = tv[i].ld;
            @(negedge clk);
            chk($sformatf("vec%0d stall", i), 32'(if2.mem_stall_I), 32'(tv[i].st));
            chk($sformatf("vec%0d rdata", i), if2.mem_rdata_I, tv[i].rd);
            chk($sformatf("vec%0d err", i), 32'(if2.mem_err_I), 32'(tv[i].er));
        end
        tick();
        load_we = 0; if2.mem_ren_I = 0;

        // LATENCY=4: full fetch, then reset in the second WAIT cycle of the next one
        if4.mem_ren_I = 1; if4.mem_addr_I = 2;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            chk($sformatf("lat4 stall c%0d", k), 32'(if4.mem_stall_I), 1);
        end
        tick();
        @(negedge clk);
        chk("lat4 resp stall", 32'(if4.mem_stall_I), 0);
        chk("lat4 resp rdata", if4.mem_rdata_I, 32'h002081b3);
        tick();
        if4.mem_addr_I = 3;
        @(negedge clk);
        chk("lat4 refetch c0 stall", 32'(if4.mem_stall_I), 1);
        tick();
        tick();
        @(negedge clk);
        chk("lat4 wait2 stall", 32'(if4.mem_stall_I), 1);
        #1;
        rst_n = 1'b0; if4.mem_ren_I = 0;
        #1;
        chk("midreset u4 stall", 32'(if4.mem_stall_I), 0);
        chk("midreset u4 rdata", if4.mem_rdata_I, 32'h0);
        chk("midreset u4 err", 32'(if4.mem_err_I), 0);
        chk("midreset u2 rdata", if2.mem_rdata_I, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        if4.mem_ren_I = 1; if4.mem_addr_I = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            chk($sformatf("postreset stall c%0d", k), 32'(if4.mem_stall_I), 1);
        end
        tick();
        @(negedge clk);
        chk("postreset stall", 32'(if4.mem_stall_I), 0);
        chk("postreset rdata", if4.mem_rdata_I, 32'h00500093);
        tick();
        if4.mem_ren_I = 0;

        // LATENCY=1: one stall cycle, data next cycle, back-to-back
        if1.mem_ren_I = 1; if1.mem_addr_I = 3;
        @(negedge clk);
        chk("lat1 c0 stall", 32'(if1.mem_stall_I), 1);
        tick();
        @(negedge clk);
        chk("lat1 c1 stall", 32'(if1.mem_stall_I), 0);
        chk("lat1 c1 rdata", if1.mem_rdata_I, 32'hfe000ee3);
        chk("lat1 c1 err", 32'(if1.mem_err_I), 0);
        tick();
        if1.mem_addr_I = 1;
        @(negedge clk);
        chk("lat1 c2 stall", 32'(if1.mem_stall_I), 1);
        chk("lat1 c2 rdata hold", if1.mem_rdata_I, 32'hfe000ee3);
        tick();
        @(negedge clk);
        chk("lat1 c3 stall", 32'(if1.mem_stall_I), 0);
        chk("lat1 c3 rdata", if1.mem_rdata_I, 32'h00108113);
        tick();
        if1.mem_ren_I = 0;
        @(negedge clk);
        chk("lat1 idle stall", 32'(if1.mem_stall_I), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the fetch/decode stage's instruction port. It answers word-address fetch requests after a fixed number of wait states, holding the requester with a stall signal until the word is ready. It also exposes a program-load write port so the bench or boot logic can fill the array before or between runs. It sits between the core's fetch address bus and the on-chip instruction store.

## Interface
Parameters:
- DEPTH_LOG2, 8: log2 of the number of 32-bit words stored (256 words by default).
- LATENCY, 2: wait states per fetch. Legal range is 1..15.
- NOP_WORD, 32'h00000013: word returned for out-of-range addresses (addi x0,x0,0).

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1: system clock. All state changes on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- mem_addr_I, input, [31:2]: word address from the fetch stage.
- mem_ren_I, input, 1: fetch request. The requester holds it high, with mem_addr_I stable, until stall drops.
- mem_rdata_I, output, 32: fetched instruction word. Registered.
- mem_stall_I, output, 1: requester must hold its request while this is high.
- mem_err_I, output, 1: high in the response cycle when the address was out of range.
- load_we, input, 1: program-load write strobe.
- load_addr, input, DEPTH_LOG2: program-load word index.
- load_data, input, 32: program-load data.

## Operation
- The storage array is 2^DEPTH_LOG2 x 32 bits.
  - It is not cleared by reset; contents survive rst_n.
  - Reading a never-written word returns X.
- The state machine has three states: IDLE, WAIT and RESP.
- IDLE:
  - mem_stall_I = mem_ren_I (combinational).
  - On an edge with mem_ren_I=1: latch mem_addr_I into addr_q, load cnt with LATENCY-1, then go to RESP if cnt==0, otherwise to WAIT.
- WAIT:
  - mem_stall_I = 1.
  - cnt decrements each edge. On the edge where cnt==1 (reaching 0), go to RESP.
- Array read:
  - Performed on the edge that enters RESP.
  - mem_rdata_I is loaded with array[addr_q[DEPTH_LOG2+1:2]].
  - If addr_q[31:DEPTH_LOG2+2] != 0, it is loaded with NOP_WORD instead, and mem_err_I is set.
- RESP:
  - mem_stall_I = 0; mem_rdata_I is valid.
  - On the next edge, go unconditionally to IDLE and clear mem_err_I.
  - A request still high in the cycle after RESP counts as a new fetch.
- Address changes while in WAIT are ignored; addr_q is authoritative.
- mem_rdata_I holds its last value outside RESP.
- mem_err_I is high only in RESP.
- Load port:
  - load_we writes array[load_addr] = load_data on the edge, in any state.
  - A write on the same edge as the RESP-entry read, to the read index, is forwarded: mem_rdata_I takes load_data (write-first).
- mem_ren_I falling while in WAIT is a protocol violation. The fetch completes anyway (RESP is still entered), and no error is flagged.

## Timing
- Reset values:
  - state = IDLE, cnt = 0.
  - mem_rdata_I = 32'h0, mem_err_I = 0.
  - mem_stall_I = 0 (with mem_ren_I low).
- Assertion of rst_n=0 mid-fetch returns immediately to IDLE, drops stall and zeroes the outputs. The pending fetch is discarded and the array is untouched.
- Latency:
  - A request sampled in cycle 0 is held with stall high for cycles 0..LATENCY-1.
  - In cycle LATENCY, stall is low and data is valid.
- Throughput is one fetch per LATENCY+1 cycles.
- The combinational path is mem_ren_I -> mem_stall_I in IDLE only. All other outputs are registered.
- Simultaneous load_we and fetch to different indices: both complete with no interaction.

## Test plan
- Load and fetch:
  - Stimulus: reset, then write words 0..3 = 32'h00500093, 32'h00108113, 32'h002081b3, 32'hfe000ee3. With LATENCY=2, fetch mem_addr_I=1.
  - Response: stall high for 2 cycles; in cycle 2, stall=0 and mem_rdata_I=32'h00108113, mem_err_I=0.
- Back-to-back fetches:
  - Stimulus: hold mem_ren_I high and step addresses 0,1,2,3 after each stall drop.
  - Response: four responses spaced 3 cycles apart, carrying the loaded words in order.
- Out-of-range address:
  - Stimulus: fetch mem_addr_I=30'h100 with DEPTH_LOG2=8.
  - Response: mem_rdata_I=32'h00000013 and mem_err_I=1 for exactly one cycle.
- Write-first forwarding:
  - Stimulus: fetch index 5 (old value 32'hAAAAAAAA). On the RESP-entry edge, load_we writes index 5 with 32'h12345678.
  - Response: mem_rdata_I=32'h12345678.
- Reset mid-fetch:
  - Stimulus: with LATENCY=4, assert rst_n=0 in the second WAIT cycle.
  - Response: stall=0 and rdata=0 immediately. After release, fetching index 0 returns the preloaded 32'h00500093, confirming the array is retained.
- LATENCY=1:
  - Stimulus: fetch with LATENCY=1.
  - Response: stall high for one cycle, data in the next cycle, no WAIT state visited.
